// File: rtl/spmp_seq_checker.sv
// rtl/spmp_seq_checker.sv - multi-cycle SPMP permission checker scanning ENTRIES_PER_CYCLE entries per cycle
// Build option SPMP_EARLY_EXIT_EN: leave the scan on the first matching group (variable latency).
module spmp_seq_checker #(
   parameter int unsigned NR_ENTRIES        = 64,
   parameter int unsigned ENTRIES_PER_CYCLE = 4,
   parameter int unsigned PLEN              = 56
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               flush_i,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  logic [PLEN-1:0]                    req_addr_i,
   input  logic [1:0]                         req_type_i,
   input  logic                               req_priv_s_i,
   input  logic [NR_ENTRIES*8-1:0]            cfg_i,
   input  logic [NR_ENTRIES*(PLEN-2)-1:0]     addr_i,
   output logic                               resp_valid_o,
   input  logic                               resp_ready_i,
   output logic                               resp_allow_o,
   output logic                               resp_matched_o,
   output logic [$clog2(NR_ENTRIES)-1:0]      resp_idx_o
);

   localparam int unsigned AW = PLEN - 2;
   localparam int unsigned IW = $clog2(NR_ENTRIES);
   localparam int unsigned G  = NR_ENTRIES / ENTRIES_PER_CYCLE;
   localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
   localparam logic [GW-1:0] G_LAST = GW'(G - 1);

`ifdef SPMP_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   g_q, g_d;
   logic [AW-1:0]   a_q, a_d;
   logic [1:0]      type_q, type_d;
   logic            priv_s_q, priv_s_d;
   logic            found_q, found_d;
   logic            allow_q, allow_d;
   logic            matched_q, matched_d;
   logic [IW-1:0]   idx_q, idx_d;

   logic [7:0]      cfg_arr  [NR_ENTRIES];
   logic [AW-1:0]   addr_arr [NR_ENTRIES];
   logic [AW-1:0]   prev_arr [NR_ENTRIES];

   logic [ENTRIES_PER_CYCLE-1:0] lane_hit;
   logic [7:0]      lane_cfg [ENTRIES_PER_CYCLE];
   logic [IW-1:0]   lane_idx [ENTRIES_PER_CYCLE];

   logic            grp_hit;
   logic [7:0]      grp_cfg;
   logic [IW-1:0]   grp_idx;

   logic            unused_addr_lsbs;
   assign unused_addr_lsbs = ^req_addr_i[1:0];

   // prev_arr holds the TOR lower bound; entry 0 is bounded below by zero
   for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_unpack
      assign cfg_arr[i]  = cfg_i[8*i +: 8];
      assign addr_arr[i] = addr_i[AW*i +: AW];
      if (i == 0) begin : g_first
         assign prev_arr[i] = '0;
      end else begin : g_rest
         assign prev_arr[i] = addr_i[AW*(i-1) +: AW];
      end
   end

   for (genvar j = 0; j < ENTRIES_PER_CYCLE; j++) begin : g_lane
      logic [AW-1:0] cur;
      logic [AW-1:0] prv;
      logic [AW-1:0] napot_dc;

      assign lane_idx[j] = IW'(32'(g_q) * ENTRIES_PER_CYCLE + 32'(j));
      assign lane_cfg[j] = cfg_arr[lane_idx[j]];
      assign cur         = addr_arr[lane_idx[j]];
      assign prv         = prev_arr[lane_idx[j]];
      // trailing ones plus the first zero above them are don't-care bits
      assign napot_dc    = cur ^ (cur + AW'(1));

      always_comb begin
         lane_hit[j] = 1'b0;
         unique case (lane_cfg[j][4:3])
            2'd1:    lane_hit[j] = (prv <= a_q) && (a_q < cur);
            2'd2:    lane_hit[j] = (a_q == cur);
            2'd3:    lane_hit[j] = ((a_q ^ cur) & ~napot_dc) == '0;
            default: lane_hit[j] = 1'b0;
         endcase
      end
   end

   always_comb begin
      grp_hit = 1'b0;
      grp_cfg = '0;
      grp_idx = '0;
      for (int j = int'(ENTRIES_PER_CYCLE) - 1; j >= 0; j--) begin
         if (lane_hit[j]) begin
            grp_hit = 1'b1;
            grp_cfg = lane_cfg[j];
            grp_idx = lane_idx[j];
         end
      end
   end

   function automatic logic perm_ok(input logic matched, input logic [7:0] cfg,
                                    input logic [1:0] typ, input logic priv_s);
      logic bit_ok;
      unique case (typ)
         2'd0:    bit_ok = cfg[0];
         2'd1:    bit_ok = cfg[1];
         2'd2:    bit_ok = cfg[2];
         default: bit_ok = 1'b0;
      endcase
      if (typ == 2'd3) begin
         return 1'b0;
      end else if (priv_s) begin
         return !matched || (cfg[7] && bit_ok);
      end else begin
         return matched && !cfg[7] && bit_ok;
      end
   endfunction

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      a_d       = a_q;
      type_d    = type_q;
      priv_s_d  = priv_s_q;
      found_d   = found_q;
      allow_d   = allow_q;
      matched_d = matched_q;
      idx_d     = idx_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               state_d  = S_SCAN;
               g_d      = '0;
               a_d      = req_addr_i[PLEN-1:2];
               type_d   = req_type_i;
               priv_s_d = req_priv_s_i;
               found_d  = 1'b0;
            end
         end
         S_SCAN: begin
            // the first matching group wins; later groups never overwrite it
            if (grp_hit && !found_q) begin
               found_d   = 1'b1;
               matched_d = 1'b1;
               idx_d     = grp_idx;
               allow_d   = perm_ok(1'b1, grp_cfg, type_q, priv_s_q);
            end
            if ((EARLY_EXIT && grp_hit) || (g_q == G_LAST)) begin
               state_d = S_RESP;
               if (!found_q && !grp_hit) begin
                  matched_d = 1'b0;
                  idx_d     = '0;
                  allow_d   = perm_ok(1'b0, 8'h00, type_q, priv_s_q);
               end
            end else begin
               g_d = g_q + GW'(1);
            end
            if (flush_i) begin
               state_d = S_IDLE;
               g_d     = '0;
            end
         end
         S_RESP: begin
            if (flush_i || resp_ready_i) begin
               state_d = S_IDLE;
               g_d     = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            g_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         g_q       <= '0;
         a_q       <= '0;
         type_q    <= '0;
         priv_s_q  <= 1'b0;
         found_q   <= 1'b0;
         allow_q   <= 1'b0;
         matched_q <= 1'b0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         a_q       <= a_d;
         type_q    <= type_d;
         priv_s_q  <= priv_s_d;
         found_q   <= found_d;
         allow_q   <= allow_d;
         matched_q <= matched_d;
         idx_q     <= idx_d;
      end
   end

   assign req_ready_o    = (state_q == S_IDLE) && !rst_i;
   assign resp_valid_o   = (state_q == S_RESP);
   assign resp_allow_o   = allow_q;
   assign resp_matched_o = matched_q;
   assign resp_idx_o     = idx_q;

endmodule

// File: tb/tb_spmp_seq_checker.sv
// tb/tb_spmp_seq_checker.sv - randomized and directed checks of spmp_seq_checker against a table-walk model
module tb_spmp_seq_checker;

   localparam int NE   = 64;
   localparam int EPC  = 4;
   localparam int PLEN = 56;
   localparam int AW   = PLEN - 2;
   localparam int G    = NE / EPC;
   localparam int IW   = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            req_valid;
   logic            req_ready;
   logic [PLEN-1:0] req_addr;
   logic [1:0]      req_type;
   logic            req_priv_s;
   logic [NE*8-1:0] cfg_v;
   logic [NE*AW-1:0] addr_v;
   logic            resp_valid;
   logic            resp_ready;
   logic            resp_allow;
   logic            resp_matched;
   logic [IW-1:0]   resp_idx;

   logic [7:0]      cfg_m  [NE];
   logic [AW-1:0]   addr_m [NE];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < NE; i++) begin : g_pack
      assign cfg_v[8*i +: 8]   = cfg_m[i];
      assign addr_v[AW*i +: AW] = addr_m[i];
   end

   spmp_seq_checker #(.NR_ENTRIES(NE), .ENTRIES_PER_CYCLE(EPC), .PLEN(PLEN)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_addr_i     (req_addr),
      .req_type_i     (req_type),
      .req_priv_s_i   (req_priv_s),
      .cfg_i          (cfg_v),
      .addr_i         (addr_v),
      .resp_valid_o   (resp_valid),
      .resp_ready_i   (resp_ready),
      .resp_allow_o   (resp_allow),
      .resp_matched_o (resp_matched),
      .resp_idx_o     (resp_idx)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Linear walk of the table in index order; first hit wins.
   task automatic model(input logic [AW-1:0] a, input logic [1:0] typ, input logic s,
                        output logic allow, output logic matched, output int idx, output int lat);
      int t;
      logic hit;
      logic p;
      logic [AW-1:0] lo;
      matched = 1'b0;
      idx     = 0;
      for (int i = 0; i < NE; i++) begin
         if (!matched) begin
            hit = 1'b0;
            case (cfg_m[i][4:3])
               2'd1: begin
                  if (i > 0) lo = addr_m[i-1];
                  else       lo = '0;
                  hit = (lo <= a) && (a < addr_m[i]);
               end
               2'd2: hit = (a == addr_m[i]);
               2'd3: begin
                  t = 0;
                  while (t < AW && addr_m[i][t]) t++;
                  hit = ((a >> (t + 1)) == (addr_m[i] >> (t + 1)));
               end
               default: hit = 1'b0;
            endcase
            if (hit) begin
               matched = 1'b1;
               idx     = i;
            end
         end
      end
      p = (typ == 2'd3) ? 1'b0 : cfg_m[idx][typ];
      if (typ == 2'd3)  allow = 1'b0;
      else if (s)       allow = !matched || (cfg_m[idx][7] && p);
      else              allow = matched && !cfg_m[idx][7] && p;
`ifdef SPMP_EARLY_EXIT_EN
      lat = matched ? (idx / EPC + 2) : (G + 1);
`else
      lat = G + 1;
`endif
   endtask

   task automatic do_req(input string tag, input logic [PLEN-1:0] addr, input logic [1:0] typ,
                         input logic s, input int hold);
      logic ea, em;
      int ei, el, n;
      model(addr[PLEN-1:2], typ, s, ea, em, ei, el);
      @(negedge clk);
      check({tag, ".ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_addr = addr; req_type = typ; req_priv_s = s;
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (!resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".latency"}, 64'(n), 64'(el));
      check({tag, ".allow"}, 64'(resp_allow), 64'(ea));
      check({tag, ".matched"}, 64'(resp_matched), 64'(em));
      check({tag, ".idx"}, 64'(resp_idx), 64'(ei));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
         check({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
         check({tag, ".hold_out"}, 64'({resp_allow, resp_matched, resp_idx}), 64'({ea, em, 6'(ei)}));
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, ".post_ready"}, 64'(req_ready), 64'd1);
      check({tag, ".post_valid"}, 64'(resp_valid), 64'd0);
   endtask

   task automatic start_req(input logic [PLEN-1:0] addr);
      @(negedge clk);
      req_valid = 1'b1; req_addr = addr; req_type = 2'd0; req_priv_s = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic clear_table();
      for (int i = 0; i < NE; i++) begin
         cfg_m[i]  = 8'h00;
         addr_m[i] = '0;
      end
   endtask

   initial begin
      logic seen;
      int mode, t;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      req_addr = '0; req_type = '0; req_priv_s = 1'b0;
      clear_table();
      repeat (3) @(negedge clk);
      check("rst.ready", 64'(req_ready), 64'd0);
      check("rst.outs", 64'({resp_valid, resp_allow, resp_matched, resp_idx}), 64'd0);
      rst = 1'b0;

      do_req("all_off", 56'h8000_0000, 2'd0, 1'b1, 0);

      cfg_m[5] = 8'h11; addr_m[5] = AW'(56'h8000_0000 >> 2);
      do_req("na4", 56'h8000_0000, 2'd0, 1'b0, 0);

      cfg_m[9] = 8'h19; addr_m[9] = AW'(56'h8000_0000 >> 2) | AW'(32'h1FFF);
      do_req("napot", 56'h8000_1234, 2'd1, 1'b0, 5);

      cfg_m[1] = 8'h00; addr_m[1] = AW'(32'h400);
      cfg_m[2] = 8'h8F; addr_m[2] = AW'(32'h800);
      cfg_m[3] = 8'h19; addr_m[3] = AW'(32'h400) | AW'(32'h1FF);
      do_req("tor_in", 56'h1FFC, 2'd2, 1'b1, 0);

      start_req(56'h1FFC);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid.ready", 64'(req_ready), 64'd0);
      check("rst_mid.outs", 64'({resp_valid, resp_allow, resp_matched, resp_idx}), 64'd0);
      rst = 1'b0;

      do_req("tor_top", 56'h2000, 2'd2, 1'b1, 0);
      do_req("tor_rsvd", 56'h1000, 2'd3, 1'b1, 0);
      addr_m[1] = AW'(32'h800); addr_m[2] = AW'(32'h400);
      do_req("tor_swap", 56'h1FFC, 2'd2, 1'b1, 0);

      start_req(56'h1FFC);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_scan.ready", 64'(req_ready), 64'd1);
      seen = 1'b0;
      repeat (20) begin
         seen |= resp_valid;
         @(negedge clk);
      end
      check("flush_scan.no_resp", 64'(seen), 64'd0);

      start_req(56'h1FFC);
      t = 0;
      while (!resp_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("flush_resp.reached", 64'(resp_valid), 64'd1);
      flush = 1'b1; resp_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; resp_ready = 1'b0;
      check("flush_resp.ready", 64'(req_ready), 64'd1);
      seen = 1'b0;
      repeat (5) begin
         seen |= resp_valid;
         @(negedge clk);
      end
      check("flush_resp.no_resp", 64'(seen), 64'd0);

      for (int r = 0; r < 8; r++) begin
         clear_table();
         for (int i = 0; i < NE; i++) begin
            mode = ($urandom % 6 == 0) ? int'($urandom_range(1, 3)) : 0;
            cfg_m[i]  = 8'($urandom);
            cfg_m[i][4:3] = 2'(mode);
            addr_m[i] = AW'($urandom_range(0, 4095));
            if (mode == 3) begin
               t = int'($urandom_range(0, 6));
               addr_m[i] = (addr_m[i] & ~((AW'(1) << (t + 1)) - AW'(1))) | ((AW'(1) << t) - AW'(1));
            end
         end
         for (int q = 0; q < 8; q++) begin
            do_req($sformatf("rnd%0d_%0d", r, q), PLEN'($urandom_range(0, 16383)),
                   2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
